// File: rtl/heater_pkg.sv
// heater_pkg
//   Shared types and default sizing for the heater PWM controller.
//   - state_t        : controller state (IDLE, RUN, DONE)
//   - NUM_BANKS_DEF  : default bank-enable word width
//   - PERIOD_W_DEF   : default period/on-time counter width
//   - RUNS_W_DEF     : default run-length / completed-period counter width
package heater_pkg;

    localparam int unsigned NUM_BANKS_DEF = 32;
    localparam int unsigned PERIOD_W_DEF  = 16;
    localparam int unsigned RUNS_W_DEF    = 16;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

endpackage : heater_pkg

// File: rtl/heater_pwm_timer.sv
// heater_pwm_timer
//   Phase counter for one PWM period plus on-window compare.
//   Ports:
//     clk, rst_n  : clock, asynchronous active-low reset
//     clear       : force phase to 0 (outside RUN, or on abort)
//     advance     : step the phase this cycle
//     period      : latched PWM period (non-zero while advancing)
//     on_len      : latched on-time
//     wrap        : phase is at period-1; next step returns to 0
//     on_next     : the phase value after this step lies inside the on-window
module heater_pwm_timer
    import heater_pkg::*;
#(
    parameter int unsigned PERIOD_W = PERIOD_W_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clear,
    input  logic                advance,
    input  logic [PERIOD_W-1:0] period,
    input  logic [PERIOD_W-1:0] on_len,
    output logic                wrap,
    output logic                on_next
);

    logic [PERIOD_W-1:0] phase;
    logic [PERIOD_W-1:0] phase_next;

    // on_next looks one step ahead so the top can register heater_en
    // and still have it line up with the phase it belongs to.
    always_comb begin
        wrap       = (phase == period - 1'b1);
        phase_next = wrap ? '0 : phase + 1'b1;
        on_next    = (phase_next < on_len);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase <= '0;
        end else if (clear) begin
            phase <= '0;
        end else if (advance) begin
            phase <= phase_next;
        end
    end

endmodule : heater_pwm_timer

// File: rtl/heater_pwm_ctrl.sv
// heater_pwm_ctrl
//   PWM duty-cycle controller driving the ring-oscillator heater bank-enable
//   word. A start pulse latches mask/period/on-time/run-length and runs the
//   PWM pattern for cfg_runs periods (0 = until stop).
//   Ports:
//     Clk, Reset_n : clock, asynchronous active-low reset
//     start, stop  : one-cycle control pulses (stop wins when both high)
//     cfg_mask     : banks driven during the on-phase
//     cfg_period   : PWM period in Clk cycles (0 rejected, sets cfg_err)
//     cfg_on       : on-time per period in Clk cycles
//     cfg_runs     : number of periods to run, 0 = unbounded
//     heater_en    : registered bank enables
//     busy         : high while running
//     done         : one-cycle pulse at run end
//     aborted      : run ended by stop; held until next accepted start
//     cfg_err      : sticky zero-period error; cleared by next accepted start
//     period_cnt   : completed periods, saturating
module heater_pwm_ctrl
    import heater_pkg::*;
#(
    parameter int unsigned NUM_BANKS = NUM_BANKS_DEF,
    parameter int unsigned PERIOD_W  = PERIOD_W_DEF,
    parameter int unsigned RUNS_W    = RUNS_W_DEF
) (
    input  logic                 Clk,
    input  logic                 Reset_n,
    input  logic                 start,
    input  logic                 stop,
    input  logic [NUM_BANKS-1:0] cfg_mask,
    input  logic [PERIOD_W-1:0]  cfg_period,
    input  logic [PERIOD_W-1:0]  cfg_on,
    input  logic [RUNS_W-1:0]    cfg_runs,
    output logic [NUM_BANKS-1:0] heater_en,
    output logic                 busy,
    output logic                 done,
    output logic                 aborted,
    output logic                 cfg_err,
    output logic [RUNS_W-1:0]    period_cnt
);

    state_t               state_q;
    logic [NUM_BANKS-1:0] mask_q;
    logic [PERIOD_W-1:0]  period_q;
    logic [PERIOD_W-1:0]  on_q;
    logic [RUNS_W-1:0]    runs_q;

    logic                 wrap;
    logic                 on_next;
    logic                 timer_clear;
    logic                 timer_advance;
    logic [RUNS_W-1:0]    cnt_inc;
    logic                 last_period;

    always_comb begin
        timer_clear   = (state_q != RUN) || stop;
        timer_advance = (state_q == RUN);
        cnt_inc       = (&period_cnt) ? period_cnt : period_cnt + 1'b1;
        last_period   = (runs_q != '0) && (cnt_inc == runs_q);
    end

    heater_pwm_timer #(
        .PERIOD_W (PERIOD_W)
    ) u_timer (
        .clk     (Clk),
        .rst_n   (Reset_n),
        .clear   (timer_clear),
        .advance (timer_advance),
        .period  (period_q),
        .on_len  (on_q),
        .wrap    (wrap),
        .on_next (on_next)
    );

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q    <= IDLE;
            mask_q     <= '0;
            period_q   <= '0;
            on_q       <= '0;
            runs_q     <= '0;
            heater_en  <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            aborted    <= 1'b0;
            cfg_err    <= 1'b0;
            period_cnt <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    done <= 1'b0;
                    if (start && !stop) begin
                        if (cfg_period == '0) begin
                            cfg_err <= 1'b1;
                        end else begin
                            mask_q     <= cfg_mask;
                            period_q   <= cfg_period;
                            on_q       <= cfg_on;
                            runs_q     <= cfg_runs;
                            period_cnt <= '0;
                            aborted    <= 1'b0;
                            cfg_err    <= 1'b0;
                            busy       <= 1'b1;
                            // Timer still holds the previous config this
                            // cycle, so phase 0's window is decided from
                            // the raw inputs.
                            heater_en  <= (cfg_on != '0) ? cfg_mask : '0;
                            state_q    <= RUN;
                        end
                    end
                end

                RUN: begin
                    if (stop) begin
                        heater_en <= '0;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        aborted   <= 1'b1;
                        state_q   <= DONE;
                    end else if (wrap && last_period) begin
                        period_cnt <= cnt_inc;
                        heater_en  <= '0;
                        busy       <= 1'b0;
                        done       <= 1'b1;
                        state_q    <= DONE;
                    end else begin
                        if (wrap) begin
                            period_cnt <= cnt_inc;
                        end
                        heater_en <= on_next ? mask_q : '0;
                    end
                end

                DONE: begin
                    heater_en <= '0;
                    busy      <= 1'b0;
                    done      <= 1'b0;
                    state_q   <= IDLE;
                end

                default: begin
                    heater_en <= '0;
                    busy      <= 1'b0;
                    done      <= 1'b0;
                    state_q   <= IDLE;
                end
            endcase
        end
    end

endmodule : heater_pwm_ctrl
